ibex_load_resp_assembler: RTL and testbench

- Sits between the data-bus response port and the writeback stage.
- Collects one or two bus response beats per load and aligns, sign-extends and merges them.
- Produces the LSU register-file write (integer or memory-format capability) plus response valid/error consumed by writeback.
- Handles 2-beat misaligned integer loads and 2-beat tagged capability loads (CHERI memory format: 64 data bits + tag).

---
 rtl/ibex_load_resp_assembler.sv | 166 ++++++++++++++++
 tb/tb_ibex_load_resp_assembler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_load_resp_assembler.sv
// Load response assembler: sits between the data-bus response port and writeback.
// Collects one or two response beats per load, then aligns, sign-extends and merges them
// into an integer or memory-format capability register-file write. The final-beat outputs
// are combinational, so the result is usable in the same cycle as the last beat.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   load_start_i ... load_rd_i  load issue (type, sign-ext, addr[1:0], rd!=x0)
//   ready_o                  idle, may accept load_start_i
//   data_rvalid_i ... data_err_i  bus response beat (data, tag, error)
//   rf_we_lsu_o, rf_wcap_lsu_o  register-file write enable / capability write
//   rf_wdata_int_lsu_o       integer load result
//   rf_wdata_cap_lsu_o       memory-format capability {tag, word1, word0}
//   lsu_resp_valid_o, lsu_resp_err_o  load completion and error
module ibex_load_resp_assembler #(
  parameter int unsigned MemCapWidth = 65,
  parameter bit          ResetAll    = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_start_i,
  input  logic [1:0]             load_type_i,
  input  logic                   load_sign_ext_i,
  input  logic [1:0]             load_offset_i,
  input  logic                   load_rd_i,
  output logic                   ready_o,
  input  logic                   data_rvalid_i,
  input  logic [31:0]            data_rdata_i,
  input  logic                   data_rtag_i,
  input  logic                   data_err_i,
  output logic                   rf_we_lsu_o,
  output logic                   rf_wcap_lsu_o,
  output logic [31:0]            rf_wdata_int_lsu_o,
  output logic [MemCapWidth-1:0] rf_wdata_cap_lsu_o,
  output logic                   lsu_resp_valid_o,
  output logic                   lsu_resp_err_o
);

  localparam logic [1:0] TypeWord = 2'b00;
  localparam logic [1:0] TypeHalf = 2'b01;
  localparam logic [1:0] TypeByte = 2'b10;
  localparam logic [1:0] TypeCap  = 2'b11;

  typedef enum logic [1:0] {StIdle, StWaitLast, StWaitFirstOfTwo} state_e;

  state_e      state_q;
  logic [1:0]  type_q;
  logic [1:0]  offset_q;
  logic        sign_ext_q;
  logic        rd_q;
  logic        two_beat_q;

  // First-beat holding registers for two-beat loads
  logic [31:0] beat0_q;
  logic        tag0_q;
  logic        err0_q;

  logic        two_beat_start;
  logic        capture_first;
  logic        complete;
  logic        resp_err;
  logic [63:0] src;
  logic [63:0] aligned;
  logic [64:0] cap_full;

  assign two_beat_start = ((load_type_i == TypeWord) && (load_offset_i != 2'd0)) ||
                          ((load_type_i == TypeHalf) && (load_offset_i == 2'd3)) ||
                          (load_type_i == TypeCap);

  assign ready_o       = (state_q == StIdle);
  assign capture_first = (state_q == StWaitFirstOfTwo) && data_rvalid_i;
  assign complete      = (state_q == StWaitLast) && data_rvalid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      type_q     <= TypeWord;
      offset_q   <= 2'd0;
      sign_ext_q <= 1'b0;
      rd_q       <= 1'b0;
      two_beat_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_start_i) begin
            type_q     <= load_type_i;
            offset_q   <= load_offset_i;
            sign_ext_q <= load_sign_ext_i;
            rd_q       <= load_rd_i;
            two_beat_q <= two_beat_start;
            state_q    <= two_beat_start ? StWaitFirstOfTwo : StWaitLast;
          end
        end
        StWaitFirstOfTwo: if (data_rvalid_i) state_q <= StWaitLast;
        StWaitLast:       if (data_rvalid_i) state_q <= StIdle;
        default:          state_q <= StIdle;
      endcase
    end
  end

  if (ResetAll) begin : gen_hold_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        beat0_q <= 32'd0;
        tag0_q  <= 1'b0;
        err0_q  <= 1'b0;
      end else if (capture_first) begin
        beat0_q <= data_rdata_i;
        tag0_q  <= data_rtag_i;
        err0_q  <= data_err_i;
      end
    end
  end else begin : gen_hold_norst
    always_ff @(posedge clk_i) begin
      if (capture_first) begin
        beat0_q <= data_rdata_i;
        tag0_q  <= data_rtag_i;
        err0_q  <= data_err_i;
      end
    end
  end

  // A 64-bit {beat1, beat0} window shifted by the byte offset covers single-beat,
  // misaligned-word and offset-3 half loads with one shifter.
  assign src      = two_beat_q ? {data_rdata_i, beat0_q} : {32'd0, data_rdata_i};
  assign aligned  = src >> {offset_q, 3'b000};
  assign resp_err = data_err_i | (two_beat_q & err0_q);
  assign cap_full = {~resp_err & tag0_q & data_rtag_i, data_rdata_i, beat0_q};

  // All outputs stay at zero outside the final-beat cycle so the writeback OR-mux is clean.
  always_comb begin
    rf_we_lsu_o        = 1'b0;
    rf_wcap_lsu_o      = 1'b0;
    rf_wdata_int_lsu_o = 32'd0;
    rf_wdata_cap_lsu_o = '0;
    lsu_resp_valid_o   = 1'b0;
    lsu_resp_err_o     = 1'b0;
    if (complete) begin
      lsu_resp_valid_o = 1'b1;
      lsu_resp_err_o   = resp_err;
      rf_we_lsu_o      = rd_q & ~resp_err;
      unique case (type_q)
        TypeWord: rf_wdata_int_lsu_o = aligned[31:0];
        TypeHalf: rf_wdata_int_lsu_o = {{16{sign_ext_q & aligned[15]}}, aligned[15:0]};
        TypeByte: rf_wdata_int_lsu_o = {{24{sign_ext_q & aligned[7]}}, aligned[7:0]};
        TypeCap: begin
          rf_wdata_int_lsu_o = beat0_q;
          rf_wcap_lsu_o      = ~resp_err;
          rf_wdata_cap_lsu_o = MemCapWidth'(cap_full);
        end
        default: rf_wdata_int_lsu_o = 32'd0;
      endcase
    end
  end

  // Protocol checks
  a_start_when_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(load_start_i && !ready_o));
  a_cap_aligned : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (load_start_i && ready_o && (load_type_i == TypeCap)) |-> (load_offset_i == 2'd0));
  // Stray beats of a load aborted by reset land here, so this only warns.
  a_rvalid_idle : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(data_rvalid_i && (state_q == StIdle)))
    else $warning("data_rvalid_i while idle, beat ignored");

endmodule

// File: tb/tb_ibex_load_resp_assembler.sv
module tb_ibex_load_resp_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [1:0]  load_type;
  logic        load_sign_ext;
  logic [1:0]  load_offset;
  logic        load_rd;
  logic        ready;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_rtag;
  logic        data_err;
  logic        rf_we;
  logic        rf_wcap;
  logic [31:0] rf_wdata_int;
  logic [64:0] rf_wdata_cap;
  logic        resp_valid;
  logic        resp_err;

  typedef struct packed {
    logic        we;
    logic        wcap;
    logic [31:0] int_d;
    logic [64:0] cap;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   failed   = 0;

  always #5 clk = ~clk;

  ibex_load_resp_assembler #(
    .MemCapWidth(65),
    .ResetAll   (1'b0)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .load_start_i      (load_start),
    .load_type_i       (load_type),
    .load_sign_ext_i   (load_sign_ext),
    .load_offset_i     (load_offset),
    .load_rd_i         (load_rd),
    .ready_o           (ready),
    .data_rvalid_i     (data_rvalid),
    .data_rdata_i      (data_rdata),
    .data_rtag_i       (data_rtag),
    .data_err_i        (data_err),
    .rf_we_lsu_o       (rf_we),
    .rf_wcap_lsu_o     (rf_wcap),
    .rf_wdata_int_lsu_o(rf_wdata_int),
    .rf_wdata_cap_lsu_o(rf_wdata_cap),
    .lsu_resp_valid_o  (resp_valid),
    .lsu_resp_err_o    (resp_err)
  );

  // Monitor: compare every response against the scoreboard; otherwise outputs must be quiet
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clk);
      act = '{we: rf_we, wcap: rf_wcap, int_d: rf_wdata_int, cap: rf_wdata_cap, err: resp_err};
      if (resp_valid === 1'b1) begin
        compared++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_resp: got we=%0b wcap=%0b int=%h cap=%h err=%0b, none expected",
                   act.we, act.wcap, act.int_d, act.cap, act.err);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failed++;
            $display("FAIL resp: got we=%0b wcap=%0b int=%h cap=%h err=%0b, want we=%0b wcap=%0b int=%h cap=%h err=%0b",
                     act.we, act.wcap, act.int_d, act.cap, act.err,
                     e.we, e.wcap, e.int_d, e.cap, e.err);
          end
        end
      end else begin
        compared++;
        if (act !== '0 || resp_valid !== 1'b0) begin
          failed++;
          $display("FAIL quiet: got valid=%b we=%b wcap=%b int=%h cap=%h err=%b, want all zero",
                   resp_valid, act.we, act.wcap, act.int_d, act.cap, act.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic push(input logic we, input logic wcap, input logic [31:0] d,
                      input logic [64:0] cap, input logic err);
    exp_q.push_back('{we: we, wcap: wcap, int_d: d, cap: cap, err: err});
  endtask

  task automatic start_load(input logic [1:0] t, input logic s, input logic [1:0] o,
                            input logic rd);
    load_start    = 1'b1;
    load_type     = t;
    load_sign_ext = s;
    load_offset   = o;
    load_rd       = rd;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic tag, input logic err);
    data_rvalid = 1'b1;
    data_rdata  = d;
    data_rtag   = tag;
    data_err    = err;
    @(posedge clk); #1;
    data_rvalid = 1'b0;
    data_rdata  = 32'd0;
    data_rtag   = 1'b0;
    data_err    = 1'b0;
  endtask

  task automatic check_ready(input logic exp, input string name);
    compared++;
    if (ready !== exp) begin
      failed++;
      $display("FAIL %s: ready_o=%b want %b", name, ready, exp);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    load_start    = 1'b0;
    load_type     = 2'b00;
    load_sign_ext = 1'b0;
    load_offset   = 2'd0;
    load_rd       = 1'b0;
    data_rvalid   = 1'b0;
    data_rdata    = 32'd0;
    data_rtag     = 1'b0;
    data_err      = 1'b0;
    @(posedge clk); #1;
    check_ready(1'b1, "reset_ready");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned word
    push(1'b1, 1'b0, 32'hDEADBEEF, 65'd0, 1'b0);
    start_load(2'b00, 1'b0, 2'd0, 1'b1);
    check_ready(1'b0, "busy_after_start");
    send_beat(32'hDEADBEEF, 1'b0, 1'b0);
    check_ready(1'b1, "ready_after_word");

    // Byte offset 2, signed and unsigned
    push(1'b1, 1'b0, 32'hFFFFFF80, 65'd0, 1'b0);
    start_load(2'b10, 1'b1, 2'd2, 1'b1);
    send_beat(32'h00800000, 1'b0, 1'b0);
    push(1'b1, 1'b0, 32'h00000080, 65'd0, 1'b0);
    start_load(2'b10, 1'b0, 2'd2, 1'b1);
    send_beat(32'h00800000, 1'b0, 1'b0);

    // Signed byte offset 3, positive value
    push(1'b1, 1'b0, 32'h0000007F, 65'd0, 1'b0);
    start_load(2'b10, 1'b1, 2'd3, 1'b1);
    send_beat(32'h7F000000, 1'b0, 1'b0);

    // Unsigned half offset 2
    push(1'b1, 1'b0, 32'h0000BEEF, 65'd0, 1'b0);
    start_load(2'b01, 1'b0, 2'd2, 1'b1);
    send_beat(32'hBEEF0000, 1'b0, 1'b0);

    // Misaligned word offset 1: nothing on beat 1
    push(1'b1, 1'b0, 32'hDD112233, 65'd0, 1'b0);
    start_load(2'b00, 1'b0, 2'd1, 1'b1);
    send_beat(32'h11223344, 1'b0, 1'b0);
    check_ready(1'b0, "busy_between_beats");
    send_beat(32'hAABBCCDD, 1'b0, 1'b0);

    // Misaligned word offset 2
    push(1'b1, 1'b0, 32'h33445566, 65'd0, 1'b0);
    start_load(2'b00, 1'b0, 2'd2, 1'b1);
    send_beat(32'h55667788, 1'b0, 1'b0);
    send_beat(32'h11223344, 1'b0, 1'b0);

    // Signed half offset 3 across beats
    push(1'b1, 1'b0, 32'hFFFF8512, 65'd0, 1'b0);
    start_load(2'b01, 1'b1, 2'd3, 1'b1);
    send_beat(32'h12000000, 1'b0, 1'b0);
    send_beat(32'h00000085, 1'b0, 1'b0);

    // Capability, both tags set, then second tag clear
    push(1'b1, 1'b1, 32'h00001000, {1'b1, 32'h12345678, 32'h00001000}, 1'b0);
    start_load(2'b11, 1'b0, 2'd0, 1'b1);
    send_beat(32'h00001000, 1'b1, 1'b0);
    send_beat(32'h12345678, 1'b1, 1'b0);
    push(1'b1, 1'b1, 32'h00001000, {1'b0, 32'h12345678, 32'h00001000}, 1'b0);
    start_load(2'b11, 1'b0, 2'd0, 1'b1);
    send_beat(32'h00001000, 1'b1, 1'b0);
    send_beat(32'h12345678, 1'b0, 1'b0);

    // Capability with error on the second beat: no write, tag forced to 0
    push(1'b0, 1'b0, 32'h00002000, {1'b0, 32'hCAFE0001, 32'h00002000}, 1'b1);
    start_load(2'b11, 1'b0, 2'd0, 1'b1);
    send_beat(32'h00002000, 1'b1, 1'b0);
    send_beat(32'hCAFE0001, 1'b1, 1'b1);

    // Half offset 3 with error on the first beat only
    push(1'b0, 1'b0, 32'h0000CDAB, 65'd0, 1'b1);
    start_load(2'b01, 1'b0, 2'd3, 1'b1);
    send_beat(32'hAB000000, 1'b0, 1'b1);
    send_beat(32'h000000CD, 1'b0, 1'b0);

    // Reset while waiting for the last beat of a two-beat load
    start_load(2'b00, 1'b0, 2'd1, 1'b1);
    send_beat(32'h11111111, 1'b0, 1'b0);
    check_ready(1'b0, "busy_before_reset");
    rst_n = 1'b0;
    #1;
    check_ready(1'b1, "ready_in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_beat(32'h22222222, 1'b1, 1'b0);
    check_ready(1'b1, "ready_after_stray");

    // rd=0: response but no register write
    push(1'b0, 1'b0, 32'hCAFEF00D, 65'd0, 1'b0);
    start_load(2'b00, 1'b0, 2'd0, 1'b0);
    send_beat(32'hCAFEF00D, 1'b0, 1'b0);
    check_ready(1'b1, "ready_final");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
